load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the word-addressed data memory (64 x 32-bit words, 6-bit word address, combinational read gated by read enable, write on posedge clk).
- Converts RV32 byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses: byte-lane selection, sign/zero extension and misalignment detection.
- Sub-word stores use a two-cycle read-modify-write sequence.
- Pipeline-facing side uses a valid/ready request and a one-cycle response pulse.

Parameters:
- ADDR_W, 8, byte-address width; word address is ADDR_W-2 bits (6 at default).
- DATA_W, 32, data width; fixed at 32 for RV32.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width/sign encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address or illegal funct3; valid with resp_valid.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, merge/hold registers 0. req_ready is 1 after reset. mem_read and mem_write are 0 during reset.
- States: IDLE and SUB_WRITE.
- req_ready = (state == IDLE).
- Acceptance occurs in cycle T when req_valid && req_ready.
- Error check at acceptance:
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
  - Illegal funct3: 011, 110, 111; for stores, any funct3 other than 000/001/010.
  - On error: no mem_read or mem_write. At T+1: resp_valid=1, resp_err=1, resp_rdata=0. State stays IDLE.
- Load, accepted at T:
  - mem_read=1 and mem_addr=addr[ADDR_W-1:2] combinationally in T.
  - Lane select uses addr[1:0]; extension follows funct3.
  - Result is registered; resp_valid and resp_rdata appear at T+1.
  - Back-to-back loads: one per cycle.
- SW, accepted at T:
  - mem_write=1 and mem_wdata=req_wdata in T; the word is written at the posedge ending T.
  - resp_valid at T+1.
- SB/SH, accepted at T:
  - mem_read=1 in T.
  - At the posedge, merge_reg captures mem_rdata with the target byte/half replaced by req_wdata[7:0] or [15:0]. Word address is held. Go to SUB_WRITE.
  - T+1 (SUB_WRITE): req_ready=0, mem_write=1, mem_addr=held address, mem_wdata=merge_reg. Go to IDLE.
  - resp_valid at T+2.
  - Any request presented at T+1 is not accepted and must be held by the upstream stage.
- resp_valid is high for exactly one cycle per accepted request.
- mem_read and mem_write are never both high in the same cycle.
- Reset in SUB_WRITE: mem_write forced 0 that cycle, store dropped, memory unchanged, no resp_valid. req_ready is 1 in the cycle after rst deasserts.
- Read-after-write: a load accepted the cycle after a SW or SUB_WRITE sees the new data, because the memory write completes at the preceding posedge.
- Address wrap: none. The word address is a pure slice of req_addr.

Decomposition:
- Shared package/header holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encodings: ST_IDLE, ST_SUB_WRITE.
  - A misalignment predicate.
- One combinational sub-module, lsu_load_align: inputs word, addr[1:0], funct3; output extended 32-bit value.
- Merge logic, FSM and handshake stay in the top module.

Test Plan:
- Word 1 preloaded 0x00000009; LW addr 0x04 accepted at T -> mem_read=1 at T; resp_valid=1 at T+1, resp_rdata=0x00000009, resp_err=0.
- Word 2 preloaded 0x8000FF80:
  - LB 0x08 -> 0xFFFFFF80.
  - LBU 0x08 -> 0x00000080.
  - LH 0x0A -> 0xFFFF8000.
  - LHU 0x0A -> 0x00008000.
  - Issued on consecutive cycles, one resp_valid each.
- Word 1 preloaded 0x11223344; SB wdata 0x000000AB addr 0x05 at T:
  - Required: mem_read at T; req_ready=0 and mem_write=1 with mem_wdata 0x1122AB44 at T+1; resp_valid at T+2.
  - Follow with LW 0x04 -> 0x1122AB44.
  - Repeat with SH 0xBEEF addr 0x06 -> 0xBEEFAB44.
- Misaligned/illegal requests:
  - LW 0x02 and SH 0x03 -> no mem_read or mem_write; resp_valid=1, resp_err=1, resp_rdata=0 at T+1.
  - funct3 011 load -> same response.
- SB 0xFF to addr 0x00 with rst=1 during SUB_WRITE -> mem_write=0, word 0 unchanged, no resp_valid; req_ready=1 in the cycle after rst deasserts.
- SW 0xCAFEF00D to 0x08 at T, then LW 0x08 at T+1 -> resp_rdata=0xCAFEF00D at T+2. req_ready stays high throughout.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes,
// FSM state encoding and alignment/legality helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_SUB_WRITE = 1'b1
  } lsu_state_e;

  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = a[0];
      F3_W:        mis = (a != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_illegal(
    input logic [2:0] f3,
    input logic       wr
  );
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = wr;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension.
// Ports: word (memory word), addr (byte offset), funct3, ext (result).
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {addr, 3'b000};
    ext     = word;
    case (funct3)
      F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ext = {24'h0, shifted[7:0]};
      F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ext = {16'h0, shifted[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit between MEM stage and word-addressed memory.
// Ports: req_* handshake in, resp_* pulse out, mem_* memory side.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e state_q, state_d;

  logic [DATA_W-1:0] merge_q;
  logic [ADDR_W-3:0] addr_q;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_data;
  logic              accept;
  logic              req_err;
  logic              is_sw;
  logic              is_sub;
  logic              go;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = is_misaligned(req_funct3, req_addr[1:0])
                   || is_illegal(req_funct3, req_write);
  assign go        = accept && !req_err;
  assign is_sw     = req_write && (req_funct3 == F3_W);
  assign is_sub    = req_write && (req_funct3 != F3_W);

  // Loads and the read half of SB/SH both read in the accept cycle.
  assign mem_read  = !rst && go && !is_sw;
  assign mem_write = !rst && ((state_q == ST_SUB_WRITE) || (go && is_sw));
  assign mem_addr  = (state_q == ST_SUB_WRITE) ? addr_q
                   : req_addr[ADDR_W-1:2];
  assign mem_wdata = (state_q == ST_SUB_WRITE) ? merge_q : req_wdata;

  lsu_load_align u_align (
    .word   (mem_rdata),
    .addr   (req_addr[1:0]),
    .funct3 (req_funct3),
    .ext    (load_data)
  );

  always_comb begin
    merged = mem_rdata;
    if (req_funct3 == F3_B)
      merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    else
      merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (go && is_sub) state_d = ST_SUB_WRITE;
      ST_SUB_WRITE: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      merge_q    <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      if (state_q == ST_SUB_WRITE) begin
        resp_valid <= 1'b1;
      end else if (accept) begin
        if (req_err) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end else if (!req_write) begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end else if (is_sw) begin
          resp_valid <= 1'b1;
        end else begin
          merge_q <= merged;
          addr_q  <= req_addr[ADDR_W-1:2];
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Holds a 64-word memory model; checks comb and registered outputs.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  logic        pre_en;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [2:0] f3,
                       input logic [7:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic err_case(input string tag, input logic wr,
                          input logic [2:0] f3, input logic [7:0] a);
    drive(wr, f3, a, 32'hFFFF_FFFF);
    check({tag, "_rd"}, mem_read, 0);
    check({tag, "_wr"}, mem_write, 0);
    tick();
    idle();
    check({tag, "_rv"}, resp_valid, 1);
    check({tag, "_er"}, resp_err, 1);
    check({tag, "_rdata"}, resp_rdata, 0);
  endtask

  logic [2:0]  lf3 [4];
  logic [7:0]  lad [4];
  logic [31:0] lex [4];

  initial begin
    lf3 = '{3'b000, 3'b100, 3'b001, 3'b101};
    lad = '{8'h08, 8'h08, 8'h0A, 8'h0A};
    lex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};

    rst = 1'b1;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    idle();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    tick();
    check("rst_rd", mem_read, 0);
    check("rst_wr", mem_write, 0);
    preload(6'd1, 32'h00000009);
    preload(6'd2, 32'h8000FF80);
    preload(6'd0, 32'h12345678);
    rst = 1'b0;
    #1;
    check("rst_rv", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_ready", req_ready, 1);
    tick();

    // LW word 1
    drive(0, 3'b010, 8'h04, 0);
    check("lw_rd", mem_read, 1);
    check("lw_addr", mem_addr, 1);
    tick();
    idle();
    check("lw_rv", resp_valid, 1);
    check("lw_rdata", resp_rdata, 32'h9);
    check("lw_err", resp_err, 0);
    tick();

    // back-to-back sub-word loads
    for (int i = 0; i < 4; i++) begin
      drive(0, lf3[i], lad[i], 0);
      check("ld_ready", req_ready, 1);
      tick();
      check("ld_rv", resp_valid, 1);
      check("ld_rdata", resp_rdata, lex[i]);
    end
    idle();
    tick();
    check("ld_one_pulse", resp_valid, 0);

    // SB into word 1, LW held during SUB_WRITE
    preload(6'd1, 32'h11223344);
    drive(1, 3'b000, 8'h05, 32'h000000AB);
    check("sb_rd", mem_read, 1);
    check("sb_wr0", mem_write, 0);
    tick();
    drive(0, 3'b010, 8'h04, 0);
    check("sb_ready", req_ready, 0);
    check("sb_wr", mem_write, 1);
    check("sb_rd1", mem_read, 0);
    check("sb_addr", mem_addr, 1);
    check("sb_wdata", mem_wdata, 32'h1122AB44);
    check("sb_rv0", resp_valid, 0);
    tick();
    check("sb_rv", resp_valid, 1);
    check("sb_rdata", resp_rdata, 0);
    check("sb_lw_rd", mem_read, 1);
    tick();
    idle();
    check("sb_lw_rv", resp_valid, 1);
    check("sb_lw", resp_rdata, 32'h1122AB44);
    tick();

    // SH into upper half of word 1
    drive(1, 3'b001, 8'h06, 32'h0000BEEF);
    check("sh_rd", mem_read, 1);
    tick();
    idle();
    check("sh_wdata", mem_wdata, 32'hBEEFAB44);
    check("sh_wr", mem_write, 1);
    tick();
    check("sh_rv", resp_valid, 1);
    drive(0, 3'b010, 8'h04, 0);
    tick();
    idle();
    check("sh_lw", resp_rdata, 32'hBEEFAB44);
    tick();

    // misaligned and illegal requests
    err_case("lw_mis", 0, 3'b010, 8'h02);
    err_case("sh_mis", 1, 3'b001, 8'h03);
    err_case("f3_011", 0, 3'b011, 8'h00);
    err_case("sbu_ill", 1, 3'b100, 8'h00);
    tick();

    // reset during SUB_WRITE
    drive(1, 3'b000, 8'h00, 32'h000000FF);
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("rsw_wr", mem_write, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rsw_rv", resp_valid, 0);
    check("rsw_ready", req_ready, 1);
    check("rsw_mem", mem[0], 32'h12345678);
    tick();
    check("rsw_rv2", resp_valid, 0);

    // SW then LW read-after-write
    drive(1, 3'b010, 8'h08, 32'hCAFEF00D);
    check("sw_wr", mem_write, 1);
    check("sw_rd", mem_read, 0);
    check("sw_wdata", mem_wdata, 32'hCAFEF00D);
    check("sw_ready", req_ready, 1);
    tick();
    check("sw_rv", resp_valid, 1);
    drive(0, 3'b010, 8'h08, 0);
    check("raw_ready", req_ready, 1);
    check("raw_rd", mem_read, 1);
    tick();
    idle();
    check("raw_rv", resp_valid, 1);
    check("raw_rdata", resp_rdata, 32'hCAFEF00D);
    check("raw_ready2", req_ready, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
